// File: rtl/uart_tx_module.sv
// UART transmitter: accepts a DEPTH-byte word over valid/ready and sends it
// as back-to-back 8N1 frames, byte 0 first, LSB first within each byte.
module uart_tx_module #(
    parameter int clk_mhz  = 50,
    parameter int boadrate = 9600,
    parameter int DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEPTH-1:0][7:0] data,
    input  logic                  valid,
    output logic                  ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    localparam int SCALE = clk_mhz * 1000 * 1000 / boadrate;
    localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]     RELOAD   = 32'(SCALE - 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [DEPTH-1:0][7:0] r_word;
    logic [31:0]           r_baud;
    logic [2:0]            r_bit;
    logic [IDXW-1:0]       r_idx;
    logic                  r_tx;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_tick;
    logic [7:0]            w_byte;
    logic [2:0]            w_next_bit;

    assign w_tick     = (r_baud == 32'd0);
    assign w_byte     = r_word[r_idx];
    assign w_next_bit = r_bit + 3'd1;

    // Frame sequencer; tx is driven straight from r_tx so the line never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_baud  <= 32'd0;
            r_bit   <= 3'd0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (valid && r_ready) begin
                        r_word  <= data;
                        r_idx   <= '0;
                        r_bit   <= 3'd0;
                        r_baud  <= RELOAD;
                        r_tx    <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_baud  <= RELOAD;
                        r_bit   <= 3'd0;
                        r_tx    <= w_byte[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud - 32'd1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_baud <= RELOAD;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= w_next_bit;
                            r_tx  <= w_byte[w_next_bit];
                        end
                    end else begin
                        r_baud <= r_baud - 32'd1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        // Last byte returns to idle; otherwise the next start bit follows with no gap.
                        if (r_idx == LAST_IDX) begin
                            r_tx    <= 1'b1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + {{(IDXW-1){1'b0}}, 1'b1};
                            r_baud  <= RELOAD;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end
                    end else begin
                        r_baud <= r_baud - 32'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign tx    = r_tx;
    assign done  = r_done;

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed bench for uart_tx_module at SCALE=10, DEPTH=4: exact bit timing,
// busy-time input isolation, back-to-back words, mid-frame reset and loopback.
module tb_uart_tx_module;
    localparam int SCALE    = 10;
    localparam int DEPTH    = 4;
    localparam int FRAME    = 10 * SCALE;
    localparam int WORD_CYC = DEPTH * FRAME;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DEPTH-1:0][7:0] data;
    logic                  valid;
    logic                  ready;
    logic                  tx;
    logic                  busy;
    logic                  done;

    int n_pass  = 0;
    int n_total = 0;

    logic cap_tx    [0:WORD_CYC+1];
    logic cap_done  [0:WORD_CYC+1];
    logic cap_ready [0:WORD_CYC+1];

    uart_tx_module #(.clk_mhz(1), .boadrate(100000), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Ideal line level c clocks after the first start bit begins.
    function automatic logic exp_tx(input logic [31:0] w, input int c);
        logic [31:0] tmp;
        logic [7:0]  b;
        int          pos;
        if (c >= WORD_CYC) return 1'b1;
        tmp = w >> (8 * (c / FRAME));
        b   = tmp[7:0];
        pos = (c % FRAME) / SCALE;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    function automatic int wave_errs(input logic [31:0] w, input int n);
        int e = 0;
        for (int c = 0; c < n; c++)
            if (cap_tx[c] !== exp_tx(w, c)) e++;
        return e;
    endfunction

    function automatic int done_count(input int n);
        int k = 0;
        for (int c = 0; c < n; c++)
            if (cap_done[c] === 1'b1) k++;
        return k;
    endfunction

    // Records n cycles starting at the current negedge (cycle 0).
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_tx[i]    = tx;
            cap_done[i]  = done;
            cap_ready[i] = ready;
            @(negedge clk);
        end
    endtask

    // Leaves the bench on the negedge just after the accept edge.
    task automatic send(input logic [31:0] w);
        @(negedge clk);
        data  = w;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Independent mid-bit sampling receiver; counts word-valid events.
    task automatic rx_word(output logic [31:0] w, output int nvalid, output int errs);
        logic [7:0] b;
        int         guard;
        logic       spurious;
        w = '0; nvalid = 0; errs = 0; b = 8'h00; spurious = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            guard = 0;
            while (tx !== 1'b0 && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 1000) errs++;
            repeat (SCALE / 2) @(negedge clk);
            if (tx !== 1'b0) errs++;
            for (int k = 0; k < 8; k++) begin
                repeat (SCALE) @(negedge clk);
                b[k] = tx;
            end
            repeat (SCALE) @(negedge clk);
            if (tx !== 1'b1) errs++;
            w[8*i +: 8] = b;
        end
        nvalid = 1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx === 1'b0) spurious = 1'b1;
        end
        if (spurious) nvalid = nvalid + 1;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; valid = 1'b0; data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({tx, ready, busy, done} !== 4'b1100) $display("FAIL reset_state: got %b expected 1100", {tx, ready, busy, done});
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({tx, ready, busy, done} !== 4'b1100) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL idle_20: got %0d bad cycles expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_single_word();
        int e;
        send(32'h44332211);
        capture(WORD_CYC + 2);
        n_total++;
        if (cap_ready[0] !== 1'b0) $display("FAIL ready_fall: got %b expected 0", cap_ready[0]);
        else n_pass++;
        e = wave_errs(32'h44332211, WORD_CYC + 2);
        n_total++;
        if (e !== 0) $display("FAIL single_wave: got %0d bad cycles expected 0", e);
        else n_pass++;
        e = done_count(WORD_CYC);
        n_total++;
        if (e !== 0) $display("FAIL done_early: got %0d pulses expected 0", e);
        else n_pass++;
        n_total++;
        if ({cap_done[WORD_CYC], cap_done[WORD_CYC+1]} !== 2'b10)
            $display("FAIL done_at_400: got %b expected 10", {cap_done[WORD_CYC], cap_done[WORD_CYC+1]});
        else n_pass++;
        n_total++;
        if (cap_ready[WORD_CYC] !== 1'b1) $display("FAIL ready_after: got %b expected 1", cap_ready[WORD_CYC]);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int e;
        send(32'h811842E7);
        fork
            capture(WORD_CYC + 2);
            begin
                for (int i = 0; i < 390; i++) begin
                    data  = $urandom;
                    valid = ~valid;
                    @(negedge clk);
                end
                valid = 1'b0;
            end
        join
        e = wave_errs(32'h811842E7, WORD_CYC + 2);
        n_total++;
        if (e !== 0) $display("FAIL busy_wave: got %0d bad cycles expected 0", e);
        else n_pass++;
        n_total++;
        if (cap_done[WORD_CYC] !== 1'b1) $display("FAIL busy_done: got %b expected 1", cap_done[WORD_CYC]);
        else n_pass++;
        n_total++;
        if ({tx, ready, busy} !== 3'b110) $display("FAIL busy_no_restart: got %b expected 110", {tx, ready, busy});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e;
        @(negedge clk);
        data  = 32'hF00FA55A;
        valid = 1'b1;
        @(negedge clk);
        capture(WORD_CYC);
        e = wave_errs(32'hF00FA55A, WORD_CYC);
        n_total++;
        if (e !== 0) $display("FAIL b2b_wave_a: got %0d bad cycles expected 0", e);
        else n_pass++;
        n_total++;
        if ({done, ready, tx} !== 3'b111) $display("FAIL b2b_a_done: got %b expected 111", {done, ready, tx});
        else n_pass++;
        data = 32'h3CC30180;
        @(negedge clk);
        valid = 1'b0;
        capture(WORD_CYC + 2);
        n_total++;
        if (cap_tx[0] !== 1'b0) $display("FAIL b2b_gap: got %b expected 0", cap_tx[0]);
        else n_pass++;
        e = wave_errs(32'h3CC30180, WORD_CYC + 2);
        n_total++;
        if (e !== 0) $display("FAIL b2b_wave_b: got %0d bad cycles expected 0", e);
        else n_pass++;
        n_total++;
        if (cap_done[WORD_CYC] !== 1'b1) $display("FAIL b2b_done_b: got %b expected 1", cap_done[WORD_CYC]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int e;
        int bad = 0;
        send(32'h44332211);
        capture(FRAME + 4 * SCALE + SCALE / 2);
        n_total++;
        if (tx !== 1'b0) $display("FAIL pre_reset_bit3: got %b expected 0", tx);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({tx, ready, busy, done} !== 4'b1100) $display("FAIL mid_reset_state: got %b expected 1100", {tx, ready, busy, done});
        else n_pass++;
        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || tx !== 1'b1) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL mid_reset_quiet: got %0d bad cycles expected 0", bad);
        else n_pass++;
        send(32'hDEADBEEF);
        capture(WORD_CYC + 2);
        e = wave_errs(32'hDEADBEEF, WORD_CYC + 2);
        n_total++;
        if (e !== 0) $display("FAIL after_reset_wave: got %0d bad cycles expected 0", e);
        else n_pass++;
        n_total++;
        if (cap_done[WORD_CYC] !== 1'b1) $display("FAIL after_reset_done: got %b expected 1", cap_done[WORD_CYC]);
        else n_pass++;
    endtask

    task automatic test_loopback();
        logic [31:0] w;
        int          nv;
        int          errs;
        send(32'h5AFF00A5);
        rx_word(w, nv, errs);
        n_total++;
        if (errs !== 0) $display("FAIL loop_framing: got %0d errors expected 0", errs);
        else n_pass++;
        n_total++;
        if (w !== 32'h5AFF00A5) $display("FAIL loop_word: got %h expected 5aff00a5", w);
        else n_pass++;
        n_total++;
        if (nv !== 1) $display("FAIL loop_valid_once: got %0d expected 1", nv);
        else n_pass++;
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        data  = '0;
        test_reset();
        test_single_word();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
